jesd_tx_lane_seq: RTL and testbench
===================================

JESD_TX_LANE_SEQ -- requirements
Module: jesd_tx_lane_seq

Interface
REQ-001 SHALL have parameter F, default 2, octets per frame (1..8).
REQ-002 SHALL have parameter K, default 16, frames per multiframe; F*K (MF_LEN) SHALL be 17..256, otherwise elaboration fails.
REQ-003 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_sync_n  in  1  receiver SYNC~, active-low resync request.
REQ-006 SHALL have port i_data  in  8  user data octet, sampled when o_data_req=1.
REQ-007 SHALL have port i_ilas_cfg  in  112  14 ILAS config octets; octet n at bits [8n+7:8n].
REQ-008 SHALL have port i_enc_k_error  in  1  encoder invalid-K flag.
REQ-009 SHALL have port o_char  out  8  HGFEDCBA octet to encoder address.
REQ-010 SHALL have port o_k  out  1  1=control character, 0=data.
REQ-011 SHALL have port o_rd_en  out  1  encoder read enable.
REQ-012 SHALL have port o_data_req  out  1  user data accepted this cycle.
REQ-013 SHALL have port o_lmfc  out  1  one-cycle pulse when LMFC count is 0.
REQ-014 SHALL have port o_state  out  2  00 CGS, 01 ILAS, 10 DATA.
REQ-015 SHALL have port o_k_err_cnt  out  8  saturating count of i_enc_k_error cycles.

Function
REQ-016 SHALL keep free-running LMFC counter lc, 0..MF_LEN-1, wrapping to 0; o_lmfc=1 when lc==0.
REQ-017 SHALL implement states CGS, ILAS, DATA; state, counters, outputs all registered; output octet reflects state/lc of the previous cycle (latency 1).
REQ-018 CGS: SHALL emit o_char=8'hBC (K28.5), o_k=1 every cycle.
REQ-019 CGS->ILAS SHALL occur when i_sync_n==1 sampled while lc==MF_LEN-1; ILAS octet 0 aligns with lc==0.
REQ-020 ILAS SHALL last exactly 4*MF_LEN cycles, multiframe index m=0..3.
REQ-021 ILAS octet at lc: lc==0 -> K28.0 (8'h1C,k=1); lc==MF_LEN-1 -> K28.3 (8'h7C,k=1); m==1 and lc==1 -> K28.4 (8'h9C,k=1); m==1 and 2<=lc<=15 -> cfg octet lc-2, k=0; otherwise lc[7:0], k=0.
REQ-022 After last ILAS octet SHALL enter DATA; o_data_req=1 exactly while state==DATA, combinational from state register.
REQ-023 DATA: SHALL emit o_char=i_data, o_k=0, subject to REQ-031.
REQ-024 i_sync_n==0 on two consecutive cycles in ILAS or DATA SHALL return to CGS next cycle; single-cycle low SHALL be ignored.
REQ-025 Resync SHALL take priority over ILAS->DATA transition on the same cycle.
REQ-026 o_rd_en SHALL be 1 in every cycle after reset release.
REQ-027 o_k_err_cnt SHALL increment when i_enc_k_error==1, saturate at 255, clear only on reset.

Reset
REQ-028 During rst: state=CGS, lc=0, ILAS counter=0, o_char=8'hBC, o_k=1, o_rd_en=0, o_lmfc=0, o_k_err_cnt=0, sync-low filter cleared.
REQ-029 Reset asserted mid-ILAS or mid-DATA SHALL abort immediately; first cycle after release SHALL be CGS with lc counting from 0.

Configuration
REQ-030 Macro JESD_CHAR_REPLACE_EN SHALL enable character replacement in DATA.
REQ-031 With macro: last octet of a frame equal to last original octet of previous frame SHALL be replaced by K28.3 (k=1) if lc==MF_LEN-1, else K28.7 (8'hFC,k=1); comparison uses unreplaced data; reference register cleared on entry to DATA so first frame is never replaced. Without macro: data passes unmodified, no reference register.

Verification
REQ-032 Release rst, hold i_sync_n=0 for 100 cycles -> o_char=8'hBC, o_k=1, o_state=00 every cycle.
REQ-033 F=2,K=16, raise i_sync_n mid-multiframe -> ILAS starts at next lc==0; 128 ILAS octets; 8'h1C at lc 0, 8'h7C at lc 31 each multiframe, 8'h9C at m1 lc1, cfg octets at m1 lc2..15.
REQ-034 In DATA, pulse i_sync_n low 1 cycle -> stays DATA; low 2 cycles -> o_state=00 and 8'hBC next cycle.
REQ-035 JESD_CHAR_REPLACE_EN, F=2, i_data constant 8'h55 -> frame-end octets 8'hFC k=1, octet at lc 31 8'h7C k=1, first frame unreplaced; without macro all 8'h55 k=0.
REQ-036 Hold i_enc_k_error=1 for 300 cycles -> o_k_err_cnt reaches 255 and holds; assert rst -> 0.

Source files
------------

// File: rtl/jesd_tx_lane_seq.sv
// JESD204B transmit lane sequencer: CGS / ILAS / DATA with LMFC tracking.
// Optional frame-end character replacement via JESD_CHAR_REPLACE_EN.
module jesd_tx_lane_seq #(
    parameter int F = 2,
    parameter int K = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_sync_n,
    input  logic [7:0]   i_data,
    input  logic [111:0] i_ilas_cfg,
    input  logic         i_enc_k_error,
    output logic [7:0]   o_char,
    output logic         o_k,
    output logic         o_rd_en,
    output logic         o_data_req,
    output logic         o_lmfc,
    output logic [1:0]   o_state,
    output logic [7:0]   o_k_err_cnt
);
    localparam int MF_LEN = F * K;
    localparam logic [7:0] LC_LAST = 8'(MF_LEN - 1);

    generate
        if (F < 1 || F > 8 || MF_LEN < 17 || MF_LEN > 256) begin : g_bad_cfg
            $error("jesd_tx_lane_seq: unsupported F/K combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_CGS  = 2'b00,
        S_ILAS = 2'b01,
        S_DATA = 2'b10
    } state_t;

    state_t      state_q, state_d, st_q;
    logic [7:0]  lc_q, lc_d;
    logic [1:0]  mc_q, mc_d;
    logic        slow_q;
    logic [7:0]  char_q, char_d;
    logic        k_q, k_d;
    logic        lmfc_q;
    logic        rden_q;
    logic [7:0]  kerr_q, kerr_d;
    logic        lc_last;
    logic        resync;
    logic [3:0]  cfg_idx;

    assign lc_last = (lc_q == LC_LAST);
    assign resync  = (state_q != S_CGS) && !i_sync_n && slow_q;
    assign cfg_idx = lc_q[3:0] - 4'd2;

`ifdef JESD_CHAR_REPLACE_EN
    localparam logic [2:0] FC_LAST = 3'(F - 1);

    logic [2:0] fc_q, fc_d;
    logic [7:0] ref_q, ref_d;
    logic       ref_vld_q, ref_vld_d;
    logic       repl;

    // Reference holds the last unreplaced octet of the previous frame.
    always_comb begin
        fc_d      = (lc_last || fc_q == FC_LAST) ? 3'd0 : fc_q + 3'd1;
        ref_d     = ref_q;
        ref_vld_d = 1'b0;
        if (state_q == S_DATA) begin
            ref_vld_d = ref_vld_q;
            if (fc_q == FC_LAST) begin
                ref_d     = i_data;
                ref_vld_d = 1'b1;
            end
        end
    end

    assign repl = (state_q == S_DATA) && (fc_q == FC_LAST) &&
                  ref_vld_q && (i_data == ref_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            fc_q      <= 3'd0;
            ref_q     <= 8'd0;
            ref_vld_q <= 1'b0;
        end else begin
            fc_q      <= fc_d;
            ref_q     <= ref_d;
            ref_vld_q <= ref_vld_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        lc_d    = lc_last ? 8'd0 : lc_q + 8'd1;
        mc_d    = mc_q;
        char_d  = 8'hBC;
        k_d     = 1'b1;
        kerr_d  = kerr_q;
        if (i_enc_k_error && kerr_q != 8'hFF) kerr_d = kerr_q + 8'd1;
        case (state_q)
            S_CGS: begin
                if (i_sync_n && lc_last) begin
                    state_d = S_ILAS;
                    mc_d    = 2'd0;
                end
            end
            S_ILAS: begin
                if (lc_q == 8'd0) begin
                    char_d = 8'h1C;
                end else if (lc_last) begin
                    char_d = 8'h7C;
                end else if (mc_q == 2'd1 && lc_q == 8'd1) begin
                    char_d = 8'h9C;
                end else if (mc_q == 2'd1 && lc_q <= 8'd15) begin
                    char_d = i_ilas_cfg[{cfg_idx, 3'b000} +: 8];
                    k_d    = 1'b0;
                end else begin
                    char_d = lc_q;
                    k_d    = 1'b0;
                end
                if (lc_last) begin
                    mc_d = mc_q + 2'd1;
                    if (mc_q == 2'd3) state_d = S_DATA;
                end
            end
            S_DATA: begin
                char_d = i_data;
                k_d    = 1'b0;
`ifdef JESD_CHAR_REPLACE_EN
                if (repl) begin
                    char_d = lc_last ? 8'h7C : 8'hFC;
                    k_d    = 1'b1;
                end
`endif
            end
            default: state_d = S_CGS;
        endcase
        // Resync wins over any other transition, including ILAS->DATA.
        if (resync) state_d = S_CGS;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_CGS;
            st_q    <= S_CGS;
            lc_q    <= 8'd0;
            mc_q    <= 2'd0;
            slow_q  <= 1'b0;
            char_q  <= 8'hBC;
            k_q     <= 1'b1;
            lmfc_q  <= 1'b0;
            rden_q  <= 1'b0;
            kerr_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            st_q    <= state_q;
            lc_q    <= lc_d;
            mc_q    <= mc_d;
            slow_q  <= ~i_sync_n;
            char_q  <= char_d;
            k_q     <= k_d;
            lmfc_q  <= (lc_q == 8'd0);
            rden_q  <= 1'b1;
            kerr_q  <= kerr_d;
        end
    end

    assign o_char      = char_q;
    assign o_k         = k_q;
    assign o_rd_en     = rden_q;
    assign o_data_req  = (state_q == S_DATA);
    assign o_lmfc      = lmfc_q;
    assign o_state     = st_q;
    assign o_k_err_cnt = kerr_q;

endmodule

// File: tb/tb_jesd_tx_lane_seq.sv
// Directed testbench for jesd_tx_lane_seq (F=2, K=16, MF_LEN=32).
// Expectations follow JESD_CHAR_REPLACE_EN when it is defined.
module tb_jesd_tx_lane_seq;
    logic         clk = 1'b0;
    logic         rst;
    logic         i_sync_n;
    logic [7:0]   i_data;
    logic [111:0] i_ilas_cfg;
    logic         i_enc_k_error;
    logic [7:0]   o_char;
    logic         o_k;
    logic         o_rd_en;
    logic         o_data_req;
    logic         o_lmfc;
    logic [1:0]   o_state;
    logic [7:0]   o_k_err_cnt;

    always #5 clk = ~clk;

    jesd_tx_lane_seq #(.F(2), .K(16)) dut (
        .clk(clk), .rst(rst), .i_sync_n(i_sync_n), .i_data(i_data),
        .i_ilas_cfg(i_ilas_cfg), .i_enc_k_error(i_enc_k_error),
        .o_char(o_char), .o_k(o_k), .o_rd_en(o_rd_en),
        .o_data_req(o_data_req), .o_lmfc(o_lmfc), .o_state(o_state),
        .o_k_err_cnt(o_k_err_cnt)
    );

    int checks = 0;
    int errors = 0;
    int n = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n++;
    endtask

    typedef struct {
        int         idx;
        logic [7:0] ch;
        logic       k;
    } ilas_vec_t;

    typedef struct {
        logic [7:0] din;
        logic [7:0] ch;
        logic       k;
    } data_vec_t;

    ilas_vec_t  itbl[17];
    data_vec_t  dtbl[8];
    logic [7:0] cap_ch[128];
    logic       cap_k[128];
    logic [1:0] cap_st[128];
    logic       cap_req[128];
    bit         repl_en;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad_cgs, bad_lmfc, bad_rd, bad_st, kc, found, first;
        logic [7:0] ech;
        logic       ek;

`ifdef JESD_CHAR_REPLACE_EN
        repl_en = 1'b1;
`else
        repl_en = 1'b0;
`endif
        itbl[0]  = '{0,   8'h1C, 1'b1};
        itbl[1]  = '{1,   8'h01, 1'b0};
        itbl[2]  = '{2,   8'h02, 1'b0};
        itbl[3]  = '{28,  8'h1C, 1'b0};
        itbl[4]  = '{31,  8'h7C, 1'b1};
        itbl[5]  = '{32,  8'h1C, 1'b1};
        itbl[6]  = '{33,  8'h9C, 1'b1};
        itbl[7]  = '{34,  8'hA0, 1'b0};
        itbl[8]  = '{35,  8'hA1, 1'b0};
        itbl[9]  = '{47,  8'hAD, 1'b0};
        itbl[10] = '{48,  8'h10, 1'b0};
        itbl[11] = '{63,  8'h7C, 1'b1};
        itbl[12] = '{64,  8'h1C, 1'b1};
        itbl[13] = '{65,  8'h01, 1'b0};
        itbl[14] = '{79,  8'h0F, 1'b0};
        itbl[15] = '{96,  8'h1C, 1'b1};
        itbl[16] = '{127, 8'h7C, 1'b1};

        dtbl[0] = '{8'h11, 8'h11, 1'b0};
        dtbl[1] = '{8'h22, 8'h22, 1'b0};
        dtbl[2] = '{8'h33, 8'h33, 1'b0};
        dtbl[3] = '{8'h22, repl_en ? 8'hFC : 8'h22, repl_en};
        dtbl[4] = '{8'h44, 8'h44, 1'b0};
        dtbl[5] = '{8'h22, repl_en ? 8'hFC : 8'h22, repl_en};
        dtbl[6] = '{8'h55, 8'h55, 1'b0};
        dtbl[7] = '{8'h66, 8'h66, 1'b0};

        for (int i = 0; i < 14; i++) i_ilas_cfg[8*i +: 8] = 8'hA0 + 8'(i);
        rst = 1'b1;
        i_sync_n = 1'b0;
        i_data = 8'h00;
        i_enc_k_error = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_char", o_char, 8'hBC);
        chk("rst_k", o_k, 1);
        chk("rst_rd_en", o_rd_en, 0);
        chk("rst_lmfc", o_lmfc, 0);
        chk("rst_state", o_state, 0);
        chk("rst_kerr", o_k_err_cnt, 0);
        chk("rst_data_req", o_data_req, 0);

        rst = 1'b0;
        n = 0;
        bad_cgs = 0;
        bad_lmfc = 0;
        bad_rd = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (o_char != 8'hBC || o_k != 1'b1 || o_state != 2'b00) bad_cgs++;
            if (o_lmfc != ((n - 1) % 32 == 0)) bad_lmfc++;
            if (o_rd_en != 1'b1) bad_rd++;
        end
        chk("cgs_hold", bad_cgs, 0);
        chk("cgs_lmfc", bad_lmfc, 0);
        chk("cgs_rd_en", bad_rd, 0);

        i_sync_n = 1'b1;
        found = 0;
        for (int i = 0; i < 80 && found == 0; i++) begin
            tick();
            if (o_state == 2'b01) found = 1;
        end
        chk("ilas_found", found, 1);
        chk("ilas_start_cycle", n, 129);
        chk("ilas_start_lmfc", o_lmfc, 1);

        for (int i = 0; i < 128; i++) begin
            if (i > 0) tick();
            cap_ch[i] = o_char;
            cap_k[i] = o_k;
            cap_st[i] = o_state;
            cap_req[i] = o_data_req;
        end
        i_data = dtbl[0].din;

        bad_st = 0;
        kc = 0;
        for (int i = 0; i < 128; i++) begin
            if (cap_st[i] != 2'b01) bad_st++;
            if (cap_k[i]) kc++;
        end
        chk("ilas_state", bad_st, 0);
        chk("ilas_kchar_count", kc, 9);
        chk("ilas_req_before_end", cap_req[126], 0);
        chk("ilas_req_at_end", cap_req[127], 1);
        for (int t = 0; t < 17; t++) begin
            chk($sformatf("ilas_char[%0d]", itbl[t].idx), cap_ch[itbl[t].idx], itbl[t].ch);
            chk($sformatf("ilas_k[%0d]", itbl[t].idx), cap_k[itbl[t].idx], itbl[t].k);
        end

        bad_st = 0;
        for (int j = 0; j < 64; j++) begin
            tick();
            if (j < 8) begin
                ech = dtbl[j].ch;
                ek = dtbl[j].k;
            end else if (repl_en && (j % 2 == 1) && j >= 11) begin
                ech = (j % 32 == 31) ? 8'h7C : 8'hFC;
                ek = 1'b1;
            end else begin
                ech = 8'h55;
                ek = 1'b0;
            end
            chk($sformatf("data_char[%0d]", j), o_char, ech);
            chk($sformatf("data_k[%0d]", j), o_k, ek);
            if (o_state != 2'b10 || o_data_req != 1'b1) bad_st++;
            i_data = (j < 7) ? dtbl[j + 1].din : 8'h55;
        end
        chk("data_state", bad_st, 0);

        i_sync_n = 1'b0;
        tick();
        i_sync_n = 1'b1;
        bad_st = 0;
        repeat (4) begin
            tick();
            if (o_state != 2'b10) bad_st++;
        end
        chk("single_low_ignored", bad_st, 0);

        i_sync_n = 1'b0;
        tick();
        tick();
        i_sync_n = 1'b1;
        chk("resync_out_lag", o_state, 2'b10);
        chk("resync_req_drop", o_data_req, 0);
        tick();
        chk("resync_state", o_state, 2'b00);
        chk("resync_char", o_char, 8'hBC);
        chk("resync_k", o_k, 1);

        found = 0;
        for (int i = 0; i < 80 && found == 0; i++) begin
            tick();
            if (o_state == 2'b01) found = 1;
        end
        chk("ilas2_found", found, 1);
        chk("ilas2_char0", o_char, 8'h1C);
        for (int i = 1; i <= 128; i++) begin
            tick();
            if (i == 127) begin
                chk("prio_state_lag", o_state, 2'b01);
                chk("prio_no_data_req", o_data_req, 0);
                i_sync_n = 1'b1;
            end
            if (i == 128) begin
                chk("prio_state_cgs", o_state, 2'b00);
                chk("prio_char_bc", o_char, 8'hBC);
            end
            if (i == 125) i_sync_n = 1'b0;
        end

        i_enc_k_error = 1'b1;
        repeat (10) tick();
        chk("kerr_10", o_k_err_cnt, 10);
        repeat (290) tick();
        chk("kerr_sat", o_k_err_cnt, 255);
        i_enc_k_error = 1'b0;
        repeat (3) tick();
        chk("kerr_hold", o_k_err_cnt, 255);
        chk("pre_rst_data", o_state, 2'b10);

        rst = 1'b1;
        tick();
        chk("abort_state", o_state, 2'b00);
        chk("abort_char", o_char, 8'hBC);
        chk("abort_k", o_k, 1);
        chk("abort_rd_en", o_rd_en, 0);
        chk("abort_kerr", o_k_err_cnt, 0);
        chk("abort_req", o_data_req, 0);
        tick();
        chk("abort_lmfc", o_lmfc, 0);
        rst = 1'b0;
        n = 0;
        first = 0;
        for (int i = 0; i < 40 && first == 0; i++) begin
            tick();
            if (n == 1) begin
                chk("rel_lmfc", o_lmfc, 1);
                chk("rel_rd_en", o_rd_en, 1);
            end
            if (o_state == 2'b01) first = n;
        end
        chk("rel_ilas_cycle", first, 33);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
